// File: rtl/time_syn_pkg.sv
// Shared types and constants for the time-sync receive/calc/transmit stages.
// Frame preambles are kept here so the rx/tx stages agree on them.
package time_syn_pkg;

    typedef logic [63:0] time_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_WAIT_RET = 3'd2,
        S_CALC1    = 3'd3,
        S_CALC2    = 3'd4,
        S_APPLY    = 3'd5
    } state_t;

    localparam int unsigned TS_TICK_NS_DEF  = 8;
    localparam time_t       TS_STD_COMP_DEF = 64'd0;
    localparam logic [31:0] TS_TIMEOUT_DEF  = 32'd100000;

    localparam logic [7:0]  TS_PRE_TS       = 8'h66;
    localparam logic [7:0]  TS_PRE_STD      = 8'h88;
    localparam logic [7:0]  TS_PRE_RET      = 8'h55;

    function automatic time_t tick_to_time(input int unsigned tick_ns);
        return time_t'(tick_ns);
    endfunction

endpackage

// File: rtl/time_syn_local_clk.sv
// Local 64-bit time counter with load/adjust arbitration:
// standard-time load beats offset adjust, which beats the plain increment.
module time_syn_local_clk
    import time_syn_pkg::*;
#(
    parameter int unsigned P_TICK_NS  = TS_TICK_NS_DEF,
    parameter time_t       P_STD_COMP = TS_STD_COMP_DEF
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  std_load_i,
    input  time_t std_time_i,
    input  logic  adj_i,
    input  time_t adj_offset_i,
    output time_t local_time_o
);

    localparam time_t TICK = tick_to_time(P_TICK_NS);

    time_t local_q, local_d;

    always_comb begin
        if (std_load_i) begin
            local_d = std_time_i + P_STD_COMP + TICK;
        end else if (adj_i) begin
            local_d = local_q + TICK - adj_offset_i;
        end else begin
            local_d = local_q + TICK;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            local_q <= '0;
        end else begin
            local_q <= local_d;
        end
    end

    assign local_time_o = local_q;

endmodule

// File: rtl/time_syn_calc.sv
// Two-way (t1..t4) delay/offset exchange controller; corrects the local
// time counter by the measured offset and accepts direct standard-time loads.
module time_syn_calc
    import time_syn_pkg::*;
#(
    parameter int unsigned P_TICK_NS  = TS_TICK_NS_DEF,
    parameter time_t       P_STD_COMP = TS_STD_COMP_DEF,
    parameter logic [31:0] P_TIMEOUT  = TS_TIMEOUT_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_recv_time_stamp,
    input  logic        i_recv_ts_valid,
    input  logic [63:0] i_recv_std_time,
    input  logic        i_recv_std_valid,
    input  logic [63:0] i_recv_return_ts,
    input  logic        i_recv_return_valid,
    output logic [63:0] o_local_time,
    output logic        o_delay_req,
    output logic [63:0] o_offset,
    output logic [63:0] o_path_delay,
    output logic        o_sync_done,
    output logic        o_sync_timeout,
    output logic        o_busy
);

    state_t      state_q, state_d;
    time_t       t1_q, t1_d, t2_q, t2_d, t3_q, t3_d, t4_q, t4_d;
    time_t       d1_q, d1_d, d2_q, d2_d;
    time_t       offset_q, offset_d, path_q, path_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    time_t       local_time;
    logic        timeout_hit;
    logic [64:0] sum_w, diff_w;

    // Sign-extended 65-bit sums; dropping bit 0 is the floor (>>> 1) result.
    assign sum_w  = {d1_q[63], d1_q} + {d2_q[63], d2_q};
    assign diff_w = {d1_q[63], d1_q} - {d2_q[63], d2_q};

    assign timeout_hit = (state_q == S_WAIT_RET) && !i_recv_return_valid
                         && (tmo_cnt_q == P_TIMEOUT - 32'd1);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (i_recv_ts_valid) state_d = S_REQ;
            S_REQ:      state_d = S_WAIT_RET;
            S_WAIT_RET: begin
                if (i_recv_return_valid) state_d = S_CALC1;
                else if (timeout_hit)    state_d = S_IDLE;
            end
            S_CALC1:    state_d = S_CALC2;
            S_CALC2:    state_d = S_APPLY;
            S_APPLY:    state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy         = (state_q != S_IDLE);
        o_delay_req    = (state_q == S_REQ);
        o_sync_done    = (state_q == S_APPLY);
        o_sync_timeout = timeout_hit;
    end

    always_comb begin
        t1_d      = t1_q;
        t2_d      = t2_q;
        t3_d      = t3_q;
        t4_d      = t4_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        offset_d  = offset_q;
        path_d    = path_q;
        tmo_cnt_d = tmo_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_recv_ts_valid) begin
                    t1_d = i_recv_time_stamp;
                    t2_d = local_time;
                end
            end
            S_REQ: begin
                t3_d      = local_time;
                tmo_cnt_d = '0;
            end
            S_WAIT_RET: begin
                if (i_recv_return_valid) t4_d = i_recv_return_ts;
                else                     tmo_cnt_d = tmo_cnt_q + 32'd1;
            end
            S_CALC1: begin
                d1_d = t2_q - t1_q;
                d2_d = t4_q - t3_q;
            end
            S_CALC2: begin
                path_d   = sum_w[64:1];
                offset_d = diff_w[64:1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            t1_q      <= '0;
            t2_q      <= '0;
            t3_q      <= '0;
            t4_q      <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            offset_q  <= '0;
            path_q    <= '0;
            tmo_cnt_q <= '0;
        end else begin
            t1_q      <= t1_d;
            t2_q      <= t2_d;
            t3_q      <= t3_d;
            t4_q      <= t4_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            offset_q  <= offset_d;
            path_q    <= path_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    time_syn_local_clk #(
        .P_TICK_NS  (P_TICK_NS),
        .P_STD_COMP (P_STD_COMP)
    ) u_local_clk (
        .clk_i        (i_clk),
        .rst_ni       (i_rst),
        .std_load_i   (i_recv_std_valid),
        .std_time_i   (i_recv_std_time),
        .adj_i        (state_q == S_APPLY),
        .adj_offset_i (offset_q),
        .local_time_o (local_time)
    );

    assign o_local_time = local_time;
    assign o_offset     = offset_q;
    assign o_path_delay = path_q;

endmodule

// File: doc/time_syn_calc.md
Name: time_syn_calc

Overview:
- Downstream consumer of the control-port receive stage's timestamp/valid outputs.
- Maintains the node's 64-bit local time counter.
- Runs a two-way (t1..t4) delay/offset exchange and corrects the local time with the measured offset.
- Also accepts direct standard-time loads and drives the delay-request trigger towards the control transmit stage.

Parameters:
- P_TICK_NS, 8, nanoseconds added to local time per i_clk cycle.
- P_STD_COMP, 64'd0, fixed path compensation added when a standard time is loaded.
- P_TIMEOUT, 32'd100000, max cycles spent in WAIT_RET before abandoning the exchange.

Ports:
- i_clk  in  1  single clock.
- i_rst  in  1  reset, synchronous, active-low.
- i_recv_time_stamp  in  64  master send time t1.
- i_recv_ts_valid  in  1  1-cycle strobe qualifying i_recv_time_stamp.
- i_recv_std_time  in  64  absolute standard time.
- i_recv_std_valid  in  1  strobe for i_recv_std_time.
- i_recv_return_ts  in  64  master receive time t4 of our delay request.
- i_recv_return_valid  in  1  strobe for i_recv_return_ts.
- o_local_time  out  64  current local time.
- o_delay_req  out  1  1-cycle pulse: transmit stage sends a delay-request frame now.
- o_offset  out  64  last measured offset, signed two's complement.
- o_path_delay  out  64  last measured one-way delay, signed.
- o_sync_done  out  1  1-cycle pulse when a correction is applied.
- o_sync_timeout  out  1  1-cycle pulse on WAIT_RET timeout.
- o_busy  out  1  high whenever state != IDLE.

Behaviour:
Reset (i_rst==0 at a clock edge):
- All outputs, t1..t4 registers, timeout counter and state go to 0 / IDLE.
- Local time counter restarts at 0 the cycle after reset deasserts.

Local time:
- r_local_time += P_TICK_NS every cycle; wraps modulo 2^64.
- o_local_time is the register itself, no extra latency.

State machine (IDLE, REQ, WAIT_RET, CALC1, CALC2, APPLY):
- IDLE, i_recv_ts_valid=1: t1 <= i_recv_time_stamp, t2 <= r_local_time (value in that same cycle), go to REQ.
- REQ, exactly one cycle: o_delay_req=1 (registered, high the cycle after ts acceptance); t3 <= r_local_time in that cycle; clear timeout counter; go to WAIT_RET.
- WAIT_RET, i_recv_return_valid=1: t4 <= i_recv_return_ts, go to CALC1.
- WAIT_RET timeout: counter increments each cycle; on reaching P_TIMEOUT-1 without return, o_sync_timeout pulses and state goes to IDLE; no correction.
- CALC1: d1 = t2 - t1, d2 = t4 - t3, 64-bit signed, wrap-around tolerated.
- CALC2: o_path_delay <= (d1 + d2) >>> 1; o_offset <= (d1 - d2) >>> 1. Use 65-bit intermediates before the arithmetic shift (floor toward -inf).
- APPLY: r_local_time <= r_local_time + P_TICK_NS - o_offset; o_sync_done=1; go to IDLE.
- Latency: return strobe to o_sync_done = 3 cycles.

Boundary conditions:
- i_recv_ts_valid while not IDLE: ignored; t1/t2 unchanged.
- i_recv_return_valid while not WAIT_RET: ignored.
- Return and timeout in the same cycle: return wins.
- i_recv_std_valid in any state: r_local_time <= i_recv_std_time + P_STD_COMP + P_TICK_NS. It overrides the normal increment and an APPLY in the same cycle; that APPLY still pulses o_sync_done and updates o_offset/o_path_delay. FSM is otherwise unaffected.
- Reset mid-exchange: FSM returns to IDLE; no o_delay_req or o_sync_done is emitted.
- o_offset and o_path_delay hold their values until the next CALC2.

Decomposition:
- Shared package time_syn_pkg: state encoding, default tick/timeout constants, 64-bit time typedef, frame preamble constants (0x66 ts, 0x88 std, 0x55 return) shared with the rx/tx stages.
- One natural sub-module: time_syn_local_clk (counter plus load/adjust arbitration; std load > APPLY adjust > increment).

Test Plan:
- Basic exchange: tick=8; ts strobe t1=1000 while local=1700; return t4=1908 arrives after t3=1708 -> o_path_delay=450, o_offset=250; o_sync_done 3 cycles after return; local time steps by +8-250.
- Negative offset: t1=2000, t2=1500, t3=1508, t4=2108 -> d1=-500, d2=600, o_path_delay=50, o_offset=-550; local time jumps forward by 550.
- Timeout: ts strobe then no return; P_TIMEOUT=16 -> o_sync_timeout single pulse 16 cycles after o_delay_req; state IDLE; o_offset unchanged.
- Ignored frames: second ts strobe in WAIT_RET with t1=9999 -> t1 keeps first value; return strobe in IDLE -> no o_sync_done.
- Std load vs APPLY collision: std strobe 0x1234_0000 in the APPLY cycle -> next local = 0x1234_0000 + P_STD_COMP + 8; o_sync_done still pulses.
- Reset mid-WAIT_RET: i_rst=0 one cycle -> o_busy=0, local time=0; a later return strobe produces no response.
